target_io_router: RTL and testbench



---
 rtl/target_io_router_pkg.sv | 33 +++
 rtl/target_io_chan.sv | 154 +++++++++++++++
 rtl/target_io_router.sv | 159 +++++++++++++++
 tb/tb_target_io_router.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/target_io_router_pkg.sv
// rtl/target_io_router_pkg.sv - shared encodings for the target IO router
// Contents: pad mode encodings, per-channel FSM states, register offsets
// relative to REG_BASE, channel config record and its readback formatter.
package target_io_router_pkg;

   typedef enum logic [1:0] {
      IOMODE_Z    = 2'd0,
      IOMODE_GPIO = 2'd1,
      IOMODE_ALT  = 2'd2,
      IOMODE_OD   = 2'd3
   } iomode_t;

   typedef enum logic [1:0] {
      ST_HZ   = 2'd0,
      ST_TURN = 2'd1,
      ST_DRV  = 2'd2
   } chan_state_t;

   localparam logic [5:0] OFS_IOMODE = 6'd0;
   localparam logic [5:0] OFS_IOSTAT = 6'd1;
   localparam logic [5:0] OFS_IOEDGE = 6'd2;

   typedef struct packed {
      logic    val;
      iomode_t mode;
   } chan_cfg_t;

   // IOMODE byte layout: [2] value, [1:0] mode, upper bits read as zero.
   function automatic logic [7:0] cfg_to_byte(input chan_cfg_t c);
      return {5'b00000, c.val, c.mode};
   endfunction

endpackage

// File: rtl/target_io_chan.sv
// rtl/target_io_chan.sv - one routed target pad: drive FSM, dead time, sync, edge
// Optional feature macro: IOROUTE_EDGECAPT_EN (adds edge_clr / edge_flag).
// Ports:
//   clk, reset_i   clock, synchronous active-high reset
//   cfg            stored channel config (mode + value)
//   power_off      1 forces the pad to high-Z
//   alt            alternate drive source
//   pad            raw pad input level
//   drive          registered pad output value
//   drive_en       registered pad output enable
//   level          2-FF synchronised pad level
//   edge_clr       clear request for the edge sticky (optional)
//   edge_flag      sticky set on any change of level (optional)
module target_io_chan
   import target_io_router_pkg::*;
#(
   parameter int TURNAROUND = 4
) (
   input  logic      clk,
   input  logic      reset_i,
   input  chan_cfg_t cfg,
   input  logic      power_off,
   input  logic      alt,
   input  logic      pad,
   output logic      drive,
   output logic      drive_en,
   output logic      level
`ifdef IOROUTE_EDGECAPT_EN
   ,
   input  logic      edge_clr,
   output logic      edge_flag
`endif
);

   localparam logic [3:0] TURN_CYCLES = 4'(TURNAROUND);

   chan_state_t state, state_n;
   iomode_t     mode, mode_n, eff_mode;
   logic [3:0]  count, count_n;
   logic        drive_n, drive_en_n;
   logic        start;
   logic        sync1, sync2;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state    <= ST_HZ;
         mode     <= IOMODE_Z;
         count    <= 4'd0;
         drive    <= 1'b0;
         drive_en <= 1'b0;
         sync1    <= 1'b0;
         sync2    <= 1'b0;
      end else begin
         state    <= state_n;
         mode     <= mode_n;
         count    <= count_n;
         drive    <= drive_n;
         drive_en <= drive_en_n;
         sync1    <= pad;
         sync2    <= sync1;
      end
   end

   assign level = sync2;

   // 'mode' is the mode the channel is turning around into or driving.
   // Only a change of mode costs dead time; value changes inside the same
   // mode (GPIO level, OD release) are applied straight through.
   always_comb begin
      eff_mode   = power_off ? IOMODE_Z : cfg.mode;
      state_n    = state;
      mode_n     = mode;
      count_n    = count;
      drive_n    = 1'b0;
      drive_en_n = 1'b0;
      start      = 1'b0;

      case (state)
         ST_HZ: begin
            start = (eff_mode != IOMODE_Z);
         end
         ST_TURN, ST_DRV: begin
            if (eff_mode == IOMODE_Z) begin
               state_n = ST_HZ;
               mode_n  = IOMODE_Z;
               count_n = 4'd0;
            end else if (eff_mode != mode) begin
               start = 1'b1;
            end else if (state == ST_TURN) begin
               if (count <= 4'd1) begin
                  state_n = ST_DRV;
               end else begin
                  count_n = count - 4'd1;
               end
            end
         end
         default: begin
            state_n = ST_HZ;
            mode_n  = IOMODE_Z;
            count_n = 4'd0;
         end
      endcase

      if (start) begin
         mode_n = eff_mode;
         if (TURNAROUND == 0) begin
            state_n = ST_DRV;
            count_n = 4'd0;
         end else begin
            state_n = ST_TURN;
            count_n = TURN_CYCLES;
         end
      end

      // Outputs are registered from the next state so a mode switch can
      // never expose the new source for even one cycle without dead time.
      if (state_n == ST_DRV) begin
         case (mode_n)
            IOMODE_GPIO: begin
               drive_n    = cfg.val;
               drive_en_n = 1'b1;
            end
            IOMODE_ALT: begin
               drive_n    = alt;
               drive_en_n = 1'b1;
            end
            IOMODE_OD: begin
               drive_n    = 1'b0;
               drive_en_n = ~cfg.val;
            end
            default: begin
               drive_n    = 1'b0;
               drive_en_n = 1'b0;
            end
         endcase
      end
   end

`ifdef IOROUTE_EDGECAPT_EN
   logic sync_prev;

   // A new edge outranks a clear landing on the same cycle.
   always_ff @(posedge clk) begin
      if (reset_i) begin
         sync_prev <= 1'b0;
         edge_flag <= 1'b0;
      end else begin
         sync_prev <= sync2;
         edge_flag <= (edge_flag & ~edge_clr) | (sync2 ^ sync_prev);
      end
   end
`endif

endmodule

// File: rtl/target_io_router.sv
// rtl/target_io_router.sv - register-programmable router for NUM_IO target pads
// Optional feature macro: IOROUTE_EDGECAPT_EN (IOEDGE sticky register).
// Ports:
//   clk, reset_i                 clock, synchronous active-high reset
//   reg_address/bytecnt/datai    register bus address, byte index, write data
//   reg_read/write/addrvalid     register bus strobes
//   reg_datao                    read data, 0 when not addressed
//   reg_hypaddress/reg_hyplen    register length query
//   alt_i                        alternate drive source per pad
//   target_power_off             1 forces all pads high-Z
//   io_i / io_o / io_oe          pad input, output value, output enable
//   io_sync_o                    synchronised pad levels
module target_io_router
   import target_io_router_pkg::*;
#(
   parameter int          NUM_IO     = 8,
   parameter logic [5:0]  REG_BASE   = 6'd40,
   parameter int          TURNAROUND = 4,
   parameter int          NBYTES     = (NUM_IO + 7) / 8
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic [5:0]        reg_address,
   input  logic [15:0]       reg_bytecnt,
   input  logic [7:0]        reg_datai,
   output logic [7:0]        reg_datao,
   input  logic              reg_read,
   input  logic              reg_write,
   input  logic              reg_addrvalid,
   input  logic [5:0]        reg_hypaddress,
   output logic [15:0]       reg_hyplen,
   input  logic [NUM_IO-1:0] alt_i,
   input  logic              target_power_off,
   input  logic [NUM_IO-1:0] io_i,
   output logic [NUM_IO-1:0] io_o,
   output logic [NUM_IO-1:0] io_oe,
   output logic [NUM_IO-1:0] io_sync_o
);

   localparam logic [5:0] ADDR_IOMODE = REG_BASE + OFS_IOMODE;
   localparam logic [5:0] ADDR_IOSTAT = REG_BASE + OFS_IOSTAT;

   logic rd_en;
   logic wr_mode;
   assign rd_en   = reg_addrvalid & reg_read;
   assign wr_mode = reg_write && (reg_address == ADDR_IOMODE);

   // Bits [7:3] of write data are only meaningful to IOEDGE.
   logic unused_datai;
   assign unused_datai = ^reg_datai[7:3];

   // Readback is built as OR-chains of byte terms selected by reg_bytecnt,
   // so an out-of-range byte index simply reads zero.
   logic [NUM_IO:0][7:0] mode_acc;
   logic [NBYTES:0][7:0] stat_acc;
   logic [NBYTES*8-1:0]  stat_pad;

   assign mode_acc[0] = 8'h00;
   assign stat_acc[0] = 8'h00;

`ifdef IOROUTE_EDGECAPT_EN
   localparam logic [5:0] ADDR_IOEDGE = REG_BASE + OFS_IOEDGE;

   logic                 wr_edge;
   logic [NUM_IO-1:0]    edge_flags;
   logic [NBYTES*8-1:0]  edge_pad;
   logic [NBYTES:0][7:0] edge_acc;

   assign wr_edge     = reg_write && (reg_address == ADDR_IOEDGE);
   assign edge_acc[0] = 8'h00;

   always_comb begin
      edge_pad               = '0;
      edge_pad[NUM_IO-1:0]   = edge_flags;
   end
`endif

   always_comb begin
      stat_pad             = '0;
      stat_pad[NUM_IO-1:0] = io_sync_o;
   end

   for (genvar g = 0; g < NUM_IO; g++) begin : g_chan
      chan_cfg_t cfg;
      logic      hit;

      assign hit = (reg_bytecnt == 16'(g));

      always_ff @(posedge clk) begin
         if (reset_i) begin
            cfg <= '0;
         end else if (wr_mode && hit) begin
            cfg.val  <= reg_datai[2];
            cfg.mode <= iomode_t'(reg_datai[1:0]);
         end
      end

      assign mode_acc[g+1] = mode_acc[g] | (hit ? cfg_to_byte(cfg) : 8'h00);

      target_io_chan #(
         .TURNAROUND (TURNAROUND)
      ) u_chan (
         .clk       (clk),
         .reset_i   (reset_i),
         .cfg       (cfg),
         .power_off (target_power_off),
         .alt       (alt_i[g]),
         .pad       (io_i[g]),
         .drive     (io_o[g]),
         .drive_en  (io_oe[g]),
         .level     (io_sync_o[g])
`ifdef IOROUTE_EDGECAPT_EN
         ,
         .edge_clr  (wr_edge && (reg_bytecnt == 16'(g / 8)) && reg_datai[g % 8]),
         .edge_flag (edge_flags[g])
`endif
      );
   end

   for (genvar b = 0; b < NBYTES; b++) begin : g_byte
      logic hit;
      assign hit           = (reg_bytecnt == 16'(b));
      assign stat_acc[b+1] = stat_acc[b] | (hit ? stat_pad[b*8 +: 8] : 8'h00);
`ifdef IOROUTE_EDGECAPT_EN
      assign edge_acc[b+1] = edge_acc[b] | (hit ? edge_pad[b*8 +: 8] : 8'h00);
`endif
   end

   always_comb begin
      reg_datao = 8'h00;
      if (rd_en) begin
         if (reg_address == ADDR_IOMODE) begin
            reg_datao = mode_acc[NUM_IO];
         end else if (reg_address == ADDR_IOSTAT) begin
            reg_datao = stat_acc[NBYTES];
         end
`ifdef IOROUTE_EDGECAPT_EN
         else if (reg_address == ADDR_IOEDGE) begin
            reg_datao = edge_acc[NBYTES];
         end
`endif
      end
   end

   always_comb begin
      reg_hyplen = 16'd0;
      if (reg_hypaddress == ADDR_IOMODE) begin
         reg_hyplen = 16'(NUM_IO);
      end else if (reg_hypaddress == ADDR_IOSTAT) begin
         reg_hyplen = 16'(NBYTES);
      end
`ifdef IOROUTE_EDGECAPT_EN
      else if (reg_hypaddress == ADDR_IOEDGE) begin
         reg_hyplen = 16'(NBYTES);
      end
`endif
   end

endmodule

// File: tb/tb_target_io_router.sv
// tb/tb_target_io_router.sv - self-checking bench for target_io_router
module tb_target_io_router;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic [5:0]  reg_address = '0;
   logic [15:0] reg_bytecnt = '0;
   logic [7:0]  reg_datai = '0;
   logic [7:0]  reg_datao;
   logic        reg_read = 1'b0;
   logic        reg_write = 1'b0;
   logic        reg_addrvalid = 1'b0;
   logic [5:0]  reg_hypaddress = '0;
   logic [15:0] reg_hyplen;
   logic [7:0]  alt_i = '0;
   logic        target_power_off = 1'b0;
   logic [7:0]  io_i = '0;
   logic [7:0]  io_o;
   logic [7:0]  io_oe;
   logic [7:0]  io_sync_o;

`ifdef IOROUTE_EDGECAPT_EN
   localparam logic [15:0] EDGE_LEN = 16'd1;
   localparam logic [7:0]  EDGE_BIT5 = 8'h20;
`else
   localparam logic [15:0] EDGE_LEN = 16'd0;
   localparam logic [7:0]  EDGE_BIT5 = 8'h00;
`endif

   target_io_router dut (
      .clk              (clk),
      .reset_i          (reset_i),
      .reg_address      (reg_address),
      .reg_bytecnt      (reg_bytecnt),
      .reg_datai        (reg_datai),
      .reg_datao        (reg_datao),
      .reg_read         (reg_read),
      .reg_write        (reg_write),
      .reg_addrvalid    (reg_addrvalid),
      .reg_hypaddress   (reg_hypaddress),
      .reg_hyplen       (reg_hyplen),
      .alt_i            (alt_i),
      .target_power_off (target_power_off),
      .io_i             (io_i),
      .io_o             (io_o),
      .io_oe            (io_oe),
      .io_sync_o        (io_sync_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        wr;
      logic [5:0]  addr;
      logic [15:0] bcnt;
      logic [7:0]  wdata;
      logic        av;
      logic [7:0]  exp_rd;
      logic [5:0]  hyp;
      logic [15:0] exp_hyp;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Called at a negedge; the write is sampled by the next posedge.
   task automatic wr(input logic [5:0] a, input logic [15:0] b, input logic [7:0] d);
      reg_address   = a;
      reg_bytecnt   = b;
      reg_datai     = d;
      reg_write     = 1'b1;
      reg_addrvalid = 1'b1;
      @(negedge clk);
      reg_write     = 1'b0;
      reg_addrvalid = 1'b0;
   endtask

   task automatic rd(input logic [5:0] a, input logic [15:0] b, input logic av, output logic [7:0] d);
      reg_address   = a;
      reg_bytecnt   = b;
      reg_addrvalid = av;
      reg_read      = 1'b1;
      #1;
      d             = reg_datao;
      reg_read      = 1'b0;
      reg_addrvalid = 1'b0;
   endtask

   initial begin
      logic [7:0] d;

      vecs[0] = '{1'b0, 6'd40, 16'd0, 8'h00, 1'b1, 8'h00, 6'd40, 16'd8};
      vecs[1] = '{1'b1, 6'd40, 16'd1, 8'hFF, 1'b1, 8'h07, 6'd41, 16'd1};
      vecs[2] = '{1'b1, 6'd40, 16'd8, 8'h05, 1'b1, 8'h00, 6'd42, EDGE_LEN};
      vecs[3] = '{1'b0, 6'd40, 16'd1, 8'h00, 1'b0, 8'h00, 6'd39, 16'd0};
      vecs[4] = '{1'b1, 6'd40, 16'd6, 8'h0E, 1'b1, 8'h06, 6'd43, 16'd0};
      vecs[5] = '{1'b0, 6'd41, 16'd0, 8'h00, 1'b1, 8'h00, 6'd40, 16'd8};
      vecs[6] = '{1'b1, 6'd41, 16'd0, 8'hFF, 1'b1, 8'h00, 6'd0,  16'd0};
      vecs[7] = '{1'b0, 6'd40, 16'd1, 8'h00, 1'b1, 8'h07, 6'd41, 16'd1};

      // Reset state
      step();
      step();
      check("reset_io_oe", 32'(io_oe), 32'h00);
      check("reset_io_o", 32'(io_o), 32'h00);
      check("reset_io_sync", 32'(io_sync_o), 32'h00);
      reset_i = 1'b0;
      step();

      // Register decode / readback / length table
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].wr) wr(vecs[i].addr, vecs[i].bcnt, vecs[i].wdata);
         rd(vecs[i].addr, vecs[i].bcnt, vecs[i].av, d);
         check($sformatf("vec%0d_datao", i), 32'(d), 32'(vecs[i].exp_rd));
         reg_hypaddress = vecs[i].hyp;
         #1;
         check($sformatf("vec%0d_hyplen", i), 32'(reg_hyplen), 32'(vecs[i].exp_hyp));
         step();
      end
      check("idle_datao", 32'(reg_datao), 32'h00);

      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      step();

      // GPIO from high-Z: exactly 4 dead cycles after the config update
      wr(6'd40, 16'd3, 8'h05);
      check("ch3_hz_after_write", 32'(io_oe[3]), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("ch3_turn%0d_oe", k), 32'(io_oe[3]), 32'd0);
      end
      step();
      check("ch3_drv_oe", 32'(io_oe[3]), 32'd1);
      check("ch3_drv_o", 32'(io_o[3]), 32'd1);

      // ALT passthrough with one cycle of latency
      wr(6'd40, 16'd2, 8'h02);
      for (int k = 0; k < 5; k++) step();
      check("ch2_alt_oe", 32'(io_oe[2]), 32'd1);
      alt_i[2] = 1'b1;
      step();
      check("ch2_alt_o1", 32'(io_o[2]), 32'd1);
      alt_i[2] = 1'b0;
      step();
      check("ch2_alt_o0", 32'(io_o[2]), 32'd0);
      alt_i[2] = 1'b1;
      step();

      // ALT -> GPIO 0 costs a full turnaround
      wr(6'd40, 16'd2, 8'h01);
      check("ch2_still_drv", 32'(io_oe[2]), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("ch2_turn%0d_oe", k), 32'(io_oe[2]), 32'd0);
      end
      step();
      check("ch2_gpio_oe", 32'(io_oe[2]), 32'd1);
      check("ch2_gpio_o0", 32'(io_o[2]), 32'd0);

      // GPIO value toggle: no turnaround
      wr(6'd40, 16'd2, 8'h05);
      check("ch2_toggle_oe_a", 32'(io_oe[2]), 32'd1);
      step();
      check("ch2_toggle_oe_b", 32'(io_oe[2]), 32'd1);
      check("ch2_toggle_o1", 32'(io_o[2]), 32'd1);

      // Open drain
      wr(6'd40, 16'd0, 8'h03);
      for (int k = 0; k < 5; k++) step();
      check("ch0_od_o", 32'(io_o[0]), 32'd0);
      check("ch0_od_oe", 32'(io_oe[0]), 32'd1);
      wr(6'd40, 16'd0, 8'h07);
      step();
      check("ch0_od_release", 32'(io_oe[0]), 32'd0);
      wr(6'd40, 16'd0, 8'h03);
      step();
      check("ch0_od_pull", 32'(io_oe[0]), 32'd1);

      // All eight channels driving, then power-off
      alt_i = 8'h00;
      wr(6'd40, 16'd1, 8'h05);
      wr(6'd40, 16'd4, 8'h02);
      wr(6'd40, 16'd5, 8'h01);
      wr(6'd40, 16'd6, 8'h03);
      wr(6'd40, 16'd7, 8'h05);
      for (int k = 0; k < 5; k++) step();
      check("all_drv_oe", 32'(io_oe), 32'hFF);
      check("all_drv_o", 32'(io_o), 32'h8E);

      target_power_off = 1'b1;
      step();
      check("poff_oe", 32'(io_oe), 32'h00);
      wr(6'd40, 16'd5, 8'h05);
      check("poff_write_oe", 32'(io_oe), 32'h00);
      rd(6'd40, 16'd5, 1'b1, d);
      check("poff_write_stored", 32'(d), 32'h05);
      step();
      step();
      check("poff_hold_oe", 32'(io_oe), 32'h00);
      target_power_off = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("pon_turn%0d_oe", k), 32'(io_oe), 32'h00);
      end
      step();
      check("pon_restore_oe", 32'(io_oe), 32'hFF);
      check("pon_restore_o", 32'(io_o), 32'hAE);

      // Synchroniser, IOSTAT, IOEDGE
      io_i = 8'h20;
      step();
      check("sync_lat1", 32'(io_sync_o), 32'h00);
      step();
      check("sync_lat2", 32'(io_sync_o), 32'h20);
      rd(6'd41, 16'd0, 1'b1, d);
      check("iostat_hi", 32'(d), 32'h20);
      rd(6'd41, 16'd1, 1'b1, d);
      check("iostat_oob", 32'(d), 32'h00);
      io_i = 8'h00;
      for (int k = 0; k < 5; k++) step();
      rd(6'd41, 16'd0, 1'b1, d);
      check("iostat_lo", 32'(d), 32'h00);
      rd(6'd42, 16'd0, 1'b1, d);
      check("ioedge_set", 32'(d), 32'(EDGE_BIT5));
      wr(6'd42, 16'd0, 8'h20);
      rd(6'd42, 16'd0, 1'b1, d);
      check("ioedge_clr", 32'(d), 32'h00);
      io_i = 8'h20;
      step();
      step();
      wr(6'd42, 16'd0, 8'h20);
      rd(6'd42, 16'd0, 1'b1, d);
      check("ioedge_set_wins", 32'(d), 32'(EDGE_BIT5));

      // Reset while driving
      reset_i = 1'b1;
      step();
      check("rst_mid_oe", 32'(io_oe), 32'h00);
      check("rst_mid_o", 32'(io_o), 32'h00);
      check("rst_mid_sync", 32'(io_sync_o), 32'h00);
      reset_i = 1'b0;
      rd(6'd40, 16'd3, 1'b1, d);
      check("rst_mid_cfg", 32'(d), 32'h00);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
